// File: rtl/spi_ram_ctrl_if.sv
// Command/response bus between the SPI slave front-end and the RAM controller.
// master = SPI slave side (issues commands), slave = RAM controller.
interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  modport master (output din, rx_valid, input dout, tx_valid, cmd_err);
  modport slave  (input din, rx_valid, output dout, tx_valid, cmd_err);
endinterface

// File: rtl/spi_ram_ctrl.sv
// Byte RAM behind an SPI slave: independent write/read address pointers,
// registered read data with a one-cycle tx_valid pulse, and rejection of bad commands.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  spi_ram_ctrl_if.slave bus
);
  typedef enum logic {NO_ADDR = 1'b0, ADDR_OK = 1'b1} addr_st_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

  addr_st_e             wr_st_q, wr_st_d, rd_st_q, rd_st_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [7:0]           dout_q;
  logic                 tx_valid_q, cmd_err_q;
  logic [7:0]           mem [MEM_DEPTH];

  logic [1:0] op;
  logic [7:0] payload;
  logic       in_range;
  logic       wr_en, rd_en, rej;

  assign op       = bus.din[9:8];
  assign payload  = bus.din[7:0];
  assign in_range = {24'd0, payload} < 32'(MEM_DEPTH);

  // State register: both direction FSMs plus the registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st_q    <= NO_ADDR;
      rd_st_q    <= NO_ADDR;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= 8'h00;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      wr_st_q    <= wr_st_d;
      rd_st_q    <= rd_st_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= rd_en;
      cmd_err_q  <= rej;
      if (rd_en) dout_q <= mem[rd_addr_q];
    end
  end

  // Contents survive reset; only one access can occur per cycle since one command arrives per cycle
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q] <= payload;
  end

  // Next-state: out-of-range address loads leave pointer and state untouched
  always_comb begin
    wr_st_d   = wr_st_q;
    rd_st_d   = rd_st_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    if (bus.rx_valid && in_range && op == OP_WR_ADDR) begin
      wr_st_d   = ADDR_OK;
      wr_addr_d = ADDR_SIZE'(payload);
    end
    if (bus.rx_valid && in_range && op == OP_RD_ADDR) begin
      rd_st_d   = ADDR_OK;
      rd_addr_d = ADDR_SIZE'(payload);
    end
    if (wr_en && AUTO_INC) wr_addr_d = (wr_addr_q == LAST) ? '0 : wr_addr_q + 1'b1;
    if (rd_en && AUTO_INC) rd_addr_d = (rd_addr_q == LAST) ? '0 : rd_addr_q + 1'b1;
  end

  // Outputs: accepted data accesses and rejections
  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    rej   = 1'b0;
    if (bus.rx_valid) begin
      case (op)
        OP_WR_ADDR, OP_RD_ADDR: rej = !in_range;
        OP_WR_DATA: begin
          wr_en = (wr_st_q == ADDR_OK);
          rej   = (wr_st_q != ADDR_OK);
        end
        default: begin
          rd_en = (rd_st_q == ADDR_OK);
          rej   = (rd_st_q != ADDR_OK);
        end
      endcase
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.cmd_err  = cmd_err_q;
endmodule
